// File: rtl/rotate_arbiter_pkg.sv
// Shared constants and types for the two-requester rotate arbiter.
package rotate_arbiter_pkg;

  localparam int DATA_W = 8;
  localparam int AMT_W  = 4;

  // Direction encoding on reqN_dir
  localparam logic ROT_LEFT  = 1'b1;
  localparam logic ROT_RIGHT = 1'b0;

  // Requester ids carried on rsp_id
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Response slot occupancy; FULL is exactly rsp_valid
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/rotate_arbiter_rotator8.sv
// Purely combinational 8-bit rotator built from 1/2/4-position log stages.
module rotator8
  import rotate_arbiter_pkg::*;
(
  input  logic [7:0] data,
  input  logic       dir,
  input  logic [2:0] amt,
  output logic [7:0] result
);

  logic [7:0] s1;
  logic [7:0] s2;

  // Log-shifter stages; a 4-position rotate is the same in either direction
  always_comb begin
    s1 = data;
    if (amt[0]) s1 = (dir == ROT_LEFT) ? {data[6:0], data[7]} : {data[0], data[7:1]};
    s2 = s1;
    if (amt[1]) s2 = (dir == ROT_LEFT) ? {s1[5:0], s1[7:6]} : {s1[1:0], s1[7:2]};
    result = s2;
    if (amt[2]) result = {s2[3:0], s2[7:4]};
  end

endmodule

// File: rtl/rotate_arbiter.sv
// Round-robin arbitration of two rotate requesters onto one registered
// response channel with full backpressure.
module rotate_arbiter #(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_dir,
  input  logic [AMT_W-1:0]  req0_amt,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_dir,
  input  logic [AMT_W-1:0]  req1_amt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id
);
  import rotate_arbiter_pkg::*;

  slot_state_t       state_q;
  slot_state_t       state_d;
  logic              rr;
  logic              grant;
  logic              slot_free;
  logic              xfer;
  logic [DATA_W-1:0] sel_data;
  logic              sel_dir;
  logic [AMT_W-1:0]  sel_amt;
  logic [DATA_W-1:0] rot_result;

  // Grant: a lone requester wins; on contention the pointer owner wins
  always_comb begin
    grant = REQ0;
    if (req0_valid && req1_valid) grant = rr;
    else if (req1_valid)          grant = REQ1;
  end

  // Ready/transfer; rst_n gating keeps both readies low during reset
  always_comb begin
    slot_free  = (state_q == EMPTY) || rsp_ready;
    req0_ready = rst_n && slot_free && req0_valid && (grant == REQ0);
    req1_ready = rst_n && slot_free && req1_valid && (grant == REQ1);
    xfer       = req0_ready || req1_ready;
  end

  // Mux the granted request into the shared rotator
  always_comb begin
    sel_data = (grant == REQ1) ? req1_data : req0_data;
    sel_dir  = (grant == REQ1) ? req1_dir  : req0_dir;
    sel_amt  = (grant == REQ1) ? req1_amt  : req0_amt;
  end

  rotator8 u_rotator (
    .data   (sel_data),
    .dir    (sel_dir),
    .amt    (sel_amt[2:0]),
    .result (rot_result)
  );

  // Slot state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Slot next-state: fill on transfer, drain on consume without refill
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (xfer) state_d = FULL;
      FULL:  if (!xfer && rsp_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Slot outputs
  always_comb begin
    rsp_valid = (state_q == FULL);
  end

  // Response payload and round-robin pointer, both advanced only on transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_id   <= REQ0;
      rr       <= REQ0;
    end else if (xfer) begin
      rsp_data <= rot_result;
      rsp_id   <= grant;
      rr       <= ~grant;
    end
  end

endmodule

// File: tb/tb_rotate_arbiter.sv
// Directed self-checking bench for rotate_arbiter.
module tb_rotate_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_dir;
  logic [7:0] req0_data;
  logic [3:0] req0_amt;
  logic       req1_valid, req1_ready, req1_dir;
  logic [7:0] req1_data;
  logic [3:0] req1_amt;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_data;

  int total = 0;
  int bad   = 0;

  rotate_arbiter #(.DATA_W(8), .AMT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_dir   (req0_dir),
    .req0_amt   (req0_amt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_dir   (req1_dir),
    .req1_amt   (req1_amt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ready(input string tag, input logic r0, input logic r1);
    @(negedge clk);
    chk({tag, "_r0"}, {7'd0, req0_ready}, {7'd0, r0});
    chk({tag, "_r1"}, {7'd0, req1_ready}, {7'd0, r1});
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [7:0] d, input logic id);
    chk({tag, "_valid"}, {7'd0, rsp_valid}, {7'd0, v});
    chk({tag, "_data"},  rsp_data, d);
    chk({tag, "_id"},    {7'd0, rsp_id}, {7'd0, id});
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h00; req0_dir = 1'b0; req0_amt = 4'd0;
    req1_valid = 1'b0; req1_data = 8'h00; req1_dir = 1'b0; req1_amt = 4'd0;

    // Reset state: valid request must not see ready
    step();
    chk_ready("reset", 1'b0, 1'b0);
    chk_rsp("reset", 1'b0, 8'h00, 1'b0);

    // Single left rotate from requester 0
    req0_data = 8'hB1; req0_dir = 1'b1; req0_amt = 4'd1;
    rst_n = 1'b1;
    chk_ready("rol1", 1'b1, 1'b0);
    step();
    chk_rsp("rol1", 1'b1, 8'h63, 1'b0);

    // Right rotates from requester 1, including amount modulo 8 and zero
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 8'hB1; req1_dir = 1'b0; req1_amt = 4'd3;
    chk_ready("ror3", 1'b0, 1'b1);
    step();
    chk_rsp("ror3", 1'b1, 8'h36, 1'b1);
    req1_amt = 4'd11;
    chk_ready("ror11", 1'b0, 1'b1);
    step();
    chk_rsp("ror11", 1'b1, 8'h36, 1'b1);
    req1_amt = 4'd0;
    chk_ready("ror0", 1'b0, 1'b1);
    step();
    chk_rsp("ror0", 1'b1, 8'hB1, 1'b1);

    // Idle with consumer ready: slot drains, payload held
    req1_valid = 1'b0;
    chk_ready("idle", 1'b0, 1'b0);
    step();
    chk_rsp("idle", 1'b0, 8'hB1, 1'b1);

    // Contention: pointer is back at 0, grants alternate 0,1,0,1
    req0_valid = 1'b1; req0_data = 8'h01; req0_dir = 1'b1; req0_amt = 4'd2;
    req1_valid = 1'b1; req1_data = 8'h80; req1_dir = 1'b0; req1_amt = 4'd1;
    chk_ready("cont0", 1'b1, 1'b0);
    step();
    chk_rsp("cont0", 1'b1, 8'h04, 1'b0);
    req0_data = 8'h03;
    chk_ready("cont1", 1'b0, 1'b1);
    step();
    chk_rsp("cont1", 1'b1, 8'h40, 1'b1);
    req1_data = 8'hC0;
    chk_ready("cont2", 1'b1, 1'b0);
    step();
    chk_rsp("cont2", 1'b1, 8'h0C, 1'b0);
    req0_data = 8'h05;
    chk_ready("cont3", 1'b0, 1'b1);
    step();
    chk_rsp("cont3", 1'b1, 8'h60, 1'b1);
    req1_data = 8'h11;

    // Backpressure for three cycles: response and pointer frozen
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_ready("stall", 1'b0, 1'b0);
      step();
      chk_rsp("stall", 1'b1, 8'h60, 1'b1);
    end

    // Release: pointer owner (0) granted with no bubble
    rsp_ready = 1'b1;
    chk_ready("resume", 1'b1, 1'b0);
    step();
    chk_rsp("resume", 1'b1, 8'h14, 1'b0);

    // Reset mid-stream with a pending response; pointer is at 1 here
    #1;
    rst_n = 1'b0;
    #1;
    chk_rsp("midrst", 1'b0, 8'h00, 1'b0);
    chk_ready("midrst", 1'b0, 1'b0);
    step();
    chk_rsp("midrst_hold", 1'b0, 8'h00, 1'b0);
    req0_data = 8'h40;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_r0", {7'd0, req0_ready}, 8'h01);
    chk("post_rst_r1", {7'd0, req1_ready}, 8'h00);
    step();
    chk_rsp("post_rst0", 1'b1, 8'h01, 1'b0);
    chk_ready("post_rst1", 1'b0, 1'b1);
    step();
    chk_rsp("post_rst1", 1'b1, 8'h88, 1'b1);

    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    chk_rsp("drain", 1'b0, 8'h88, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rotate_arbiter.md
Name: rotate_arbiter

Overview:
- Shares one 8-bit rotate datapath between two requesters.
- Each requester presents an operand, a direction and a rotate amount over a valid/ready handshake.
- A round-robin arbiter picks one request per cycle. The sub-module rotator computes the result combinationally.
- The result is registered into a single response channel tagged with the requester id, with full backpressure.

Parameters:
- DATA_W, 8, operand/result width; only 8 is supported.
- AMT_W, 4, rotate-amount field width; only the low 3 bits are used.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has a request.
- req0_ready  output  1  requester 0 request accepted this cycle.
- req0_data  input  DATA_W  requester 0 operand.
- req0_dir  input  1  requester 0 direction: 1 = rotate left, 0 = rotate right.
- req0_amt  input  AMT_W  requester 0 rotate amount.
- req1_valid, req1_ready, req1_data, req1_dir, req1_amt  same as above, for requester 1.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  DATA_W  rotated result.
- rsp_id  output  1  requester that issued the result.

Behaviour:
- Reset (async assert, sync release) sets:
  - rsp_valid=0, rsp_data=0x00, rsp_id=0.
  - Round-robin pointer rr=0 (requester 0 preferred).
  - req0_ready=0 and req1_ready=0 while rst_n is low.
- Slot-free condition: slot_free = !rsp_valid || rsp_ready. The output register may load in any cycle where slot_free holds.
- Grant rule, evaluated combinationally each cycle:
  - Only one requester valid: it wins.
  - Both valid: requester rr wins.
  - Neither valid: no grant.
- reqN_ready = slot_free && (grant == N). At most one ready is high per cycle, and ready never rises without the matching valid.
- Handshake: a transfer happens on a rising edge where reqN_valid && reqN_ready. Requesters hold data/dir/amt stable while valid is high and not ready.
- Pointer update on transfer: rr <= ~granted_id. rr changes only on a transfer; on a one-requester grant it still flips to the other side.
- Latency: a request transferred at edge N appears with rsp_valid=1 after edge N, available for sampling at edge N+1. Rotation is done in the same cycle as the grant.
- Throughput: one result per cycle when rsp_ready is held high. Back-to-back grants alternate when both requesters are continuously valid.
- Output register behaviour:
  - Transfer this cycle: load rsp_data, load rsp_id, set rsp_valid=1.
  - Else if rsp_ready: clear rsp_valid, leaving data/id unchanged.
  - Otherwise: hold.
- Rotate arithmetic:
  - amount = amt[2:0]; amt[3] is ignored, i.e. modulo 8.
  - amount 0 passes the operand through unchanged.
  - Left rotate: bit i moves to bit (i+k) mod 8. Right rotate: bit i moves to bit (i-k) mod 8.
- Backpressure: while rsp_valid=1 and rsp_ready=0, both req ready=0, rr is frozen and the response is stable.
- Simultaneous events: a response consumed and a new request accepted in the same cycle gives rsp_valid staying 1 with the new data; no bubble, no loss.
- Reset mid-operation: any pending response is discarded, no request is accepted, and rr returns to 0.
- FSM: two states tracked by rsp_valid:
  - EMPTY → FULL on transfer.
  - FULL → FULL on transfer && rsp_ready.
  - FULL → EMPTY on rsp_ready && no transfer.
  - FULL holds on !rsp_ready.

Decomposition:
- Shared package holds:
  - DATA_W=8, AMT_W=4.
  - Direction constants ROT_LEFT=1, ROT_RIGHT=0.
  - Requester id constants REQ0=0, REQ1=1.
- One sub-module, rotator8: purely combinational 8-bit rotator. Inputs are operand, direction and 3-bit amount; it uses log stages of 1/2/4 positions. It is instantiated once, fed by the muxed granted request.

Test Plan:
- Single left rotate: req0 data=0xB1, dir=1, amt=1, rsp_ready=1. Expect req0_ready=1 in the same cycle, and next cycle rsp_valid=1, rsp_data=0x63, rsp_id=0.
- Right rotate with modulo: req1 data=0xB1, dir=0, amt=3 gives 0x36, id=1. Repeat with amt=11 → 0x36. Repeat with amt=0 → 0xB1.
- Contention after reset: both valid continuously with distinct data, rsp_ready=1. Grants go 0,1,0,1, one response per cycle, ids alternating, no lost or duplicated result.
- Backpressure: response pending with rsp_ready=0 for 3 cycles. Expect both ready=0, rsp_data/rsp_id stable, rr unchanged. Raise rsp_ready; the next grant goes to the pointer owner with no bubble.
- Reset mid-stream: assert rst_n low with rsp_valid=1 for 1 cycle. Outputs go immediately to rsp_valid=0, rsp_data=0x00. After release, with both valid, requester 0 is granted first.
